// File: rtl/csr_pkg.sv
// Shared CSR bus payloads, master FSM states and default timeout.
package csr_pkg;

  localparam int unsigned CSR_SELECT_W        = 16;
  localparam int unsigned CSR_ADDRESS_W       = 16;
  localparam int unsigned CSR_DATA_W          = 32;
  localparam int unsigned CSR_DEFAULT_TIMEOUT = 1024;

  typedef struct packed {
    logic                     valid;
    logic                     read_not_write;
    logic [CSR_SELECT_W-1:0]  select;
    logic [CSR_ADDRESS_W-1:0] address;
    logic [CSR_DATA_W-1:0]    data;
  } csr_request_t;

  typedef struct packed {
    logic                  ack;
    logic                  read_data_valid;
    logic [CSR_DATA_W-1:0] read_data;
  } csr_response_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } csr_master_state_t;

endpackage

// File: rtl/csr_master.sv
// CSR initiator: turns single local commands into CSR bus transactions and
// returns one response per command, with read data or a timeout flag.
module csr_master
  import csr_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = CSR_DEFAULT_TIMEOUT,
  parameter int unsigned TIMEOUT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd__valid,
  output logic                     cmd__ready,
  input  logic                     cmd__read_not_write,
  input  logic [CSR_SELECT_W-1:0]  cmd__select,
  input  logic [CSR_ADDRESS_W-1:0] cmd__address,
  input  logic [CSR_DATA_W-1:0]    cmd__data,
  output logic                     rsp__valid,
  output logic                     rsp__timeout,
  output logic [CSR_DATA_W-1:0]    rsp__read_data,
  output logic                     csr_request__valid,
  output logic                     csr_request__read_not_write,
  output logic [CSR_SELECT_W-1:0]  csr_request__select,
  output logic [CSR_ADDRESS_W-1:0] csr_request__address,
  output logic [CSR_DATA_W-1:0]    csr_request__data,
  input  logic                     csr_response__ack,
  input  logic                     csr_response__read_data_valid,
  input  logic [CSR_DATA_W-1:0]    csr_response__read_data
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX      = {TIMEOUT_WIDTH{1'b1}};

  csr_master_state_t         state;
  csr_request_t              req_q;
  csr_response_t             rsp_in;
  logic [TIMEOUT_WIDTH-1:0]  cnt;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic                      rsp_timeout_q;
  logic [CSR_DATA_W-1:0]     rsp_data_q;
  logic                      timed_out_c;
  logic [TIMEOUT_WIDTH-1:0]  cnt_inc_c;

  assign rsp_in.ack             = csr_response__ack;
  assign rsp_in.read_data_valid = csr_response__read_data_valid;
  assign rsp_in.read_data       = csr_response__read_data;

  // Saturating timeout counter next value and expiry flag.
  always_comb begin
    timed_out_c = (cnt == TIMEOUT_LAST);
    cnt_inc_c   = (cnt == CNT_MAX) ? cnt : cnt + TIMEOUT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      req_q         <= '0;
      cnt           <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd__valid && cmd_ready_q) begin
            req_q.valid          <= 1'b1;
            req_q.read_not_write <= cmd__read_not_write;
            req_q.select         <= cmd__select;
            req_q.address        <= cmd__address;
            req_q.data           <= cmd__data;
            cnt                  <= '0;
            cmd_ready_q          <= 1'b0;
            state                <= REQ;
          end
        end
        REQ: begin
          if (rsp_in.ack) begin
            req_q.valid <= 1'b0;
            cnt         <= '0;
            if (!req_q.read_not_write) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              state       <= RESP;
            end else if (rsp_in.read_data_valid) begin
              // Responder returned data in the ack cycle; skip WAIT_DATA.
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rsp_in.read_data;
              state       <= RESP;
            end else begin
              state <= WAIT_DATA;
            end
          end else if (timed_out_c) begin
            req_q.valid   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_data_q    <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        WAIT_DATA: begin
          if (rsp_in.read_data_valid) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= rsp_in.read_data;
            state       <= RESP;
          end else if (timed_out_c) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_data_q    <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt_inc_c;
          end
        end
        RESP: begin
          rsp_valid_q   <= 1'b0;
          rsp_timeout_q <= 1'b0;
          rsp_data_q    <= '0;
          cmd_ready_q   <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd__ready                  = cmd_ready_q;
  assign rsp__valid                  = rsp_valid_q;
  assign rsp__timeout                = rsp_timeout_q;
  assign rsp__read_data              = rsp_data_q;
  assign csr_request__valid          = req_q.valid;
  assign csr_request__read_not_write = req_q.read_not_write;
  assign csr_request__select         = req_q.select;
  assign csr_request__address        = req_q.address;
  assign csr_request__data           = req_q.data;

endmodule
